// File: rtl/frame_seq_ctrl.sv
// Frame sequencer for windowed streaming filters: tracks FILL/RUN/FLUSH/DONE,
// generates output TLAST / end-of-line, counts frames and checks input TLAST.
module frame_seq_ctrl #(
    parameter int LINE_W    = 1026,
    parameter int LINES     = 1024,
    parameter int PRIME_CNT = 5149,
    parameter int OUT_W     = 1024,
    parameter int CNT_W     = 21,
    parameter int FRM_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_ready,
    input  logic             in_last,
    input  logic             flush_adv,
    input  logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       state,
    output logic             out_last,
    output logic             out_eol,
    output logic [FRM_W-1:0] frame_cnt,
    output logic             err_early,
    output logic             err_late
);

    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [CNT_W-1:0] TOTAL   = CNT_W'(LINE_W * LINES);
    localparam logic [CNT_W-1:0] PRIME   = CNT_W'(PRIME_CNT);
    localparam logic [CNT_W-1:0] END_CNT = CNT_W'(LINE_W * LINES + PRIME_CNT);
    localparam logic [CNT_W-1:0] LAST_IN = CNT_W'(LINE_W * LINES - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(OUT_W - 1);

    typedef enum logic [3:0] {
        S_FILL  = 4'b0001,
        S_RUN   = 4'b0010,
        S_FLUSH = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             out_last_q,  out_last_d;
    logic [COL_W-1:0] out_col_q,   out_col_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             err_early_q, err_early_d;
    logic             err_late_q,  err_late_d;

    logic             accept;
    logic             out_hs;
    logic             rearm;
    logic [CNT_W-1:0] cnt_inc;

    assign accept  = in_valid && in_ready && (state_q == S_FILL || state_q == S_RUN);
    assign out_hs  = out_valid && out_ready;
    // out_last is only ever high in DONE, so this is the end-of-frame handshake.
    assign rearm   = out_last_q && out_hs;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_last_d  = out_last_q;
        out_col_d   = out_col_q;
        frame_cnt_d = frame_cnt_q;
        err_early_d = err_early_q;
        err_late_d  = err_late_q;

        if (clr) begin
            state_d     = S_FILL;
            cnt_d       = '0;
            out_last_d  = 1'b0;
            out_col_d   = '0;
            frame_cnt_d = '0;
            err_early_d = 1'b0;
            err_late_d  = 1'b0;
        end else if (rearm) begin
            state_d     = S_FILL;
            cnt_d       = '0;
            out_last_d  = 1'b0;
            out_col_d   = '0;
            frame_cnt_d = frame_cnt_q + FRM_W'(1);
        end else begin
            if (out_hs) begin
                out_col_d = (out_col_q == COL_MAX) ? '0 : out_col_q + COL_W'(1);
            end

            if (accept) begin
                if (in_last && cnt_q < LAST_IN) err_early_d = 1'b1;
                if (!in_last && cnt_q == LAST_IN) err_late_d = 1'b1;
            end

            unique case (state_q)
                S_FILL: if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == PRIME) state_d = S_RUN;
                end
                S_RUN: if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TOTAL) state_d = S_FLUSH;
                end
                S_FLUSH: if (flush_adv) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == END_CNT) begin
                        state_d    = S_DONE;
                        out_last_d = 1'b1;
                    end
                end
                S_DONE: ;
                default: state_d = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            out_last_q  <= 1'b0;
            out_col_q   <= '0;
            frame_cnt_q <= '0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_last_q  <= out_last_d;
            out_col_q   <= out_col_d;
            frame_cnt_q <= frame_cnt_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
        end
    end

    assign state     = state_q;
    assign out_last  = out_last_q;
    assign out_eol   = (out_col_q == COL_MAX);
    assign frame_cnt = frame_cnt_q;
    assign err_early = err_early_q;
    assign err_late  = err_late_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl with a small frame: 6x4 beats, prime/flush 9,
// output lines of 4 beats. Expected values are hand-computed constants.
module tb_frame_seq_ctrl;

    localparam int FRM_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic             flush_adv;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       state;
    logic             out_last;
    logic             out_eol;
    logic [FRM_W-1:0] frame_cnt;
    logic             err_early;
    logic             err_late;

    int errors = 0;
    int checks = 0;

    frame_seq_ctrl #(
        .LINE_W(6), .LINES(4), .PRIME_CNT(9), .OUT_W(4), .CNT_W(8), .FRM_W(FRM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .flush_adv(flush_adv), .out_valid(out_valid), .out_ready(out_ready),
        .state(state), .out_last(out_last), .out_eol(out_eol),
        .frame_cnt(frame_cnt), .err_early(err_early), .err_late(err_late)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic last);
        in_valid = 1'b1; in_ready = 1'b1; in_last = last;
        step();
        in_valid = 1'b0; in_ready = 1'b0; in_last = 1'b0;
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) beat(1'b0);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) begin
            flush_adv = 1'b1;
            step();
        end
        flush_adv = 1'b0;
    endtask

    task automatic handshake();
        out_valid = 1'b1; out_ready = 1'b1;
        step();
        out_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        in_valid = 1'b0; in_ready = 1'b0; in_last = 1'b0;
        flush_adv = 1'b0; out_valid = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state), 32'h1);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_out_eol", 32'(out_eol), 32'h0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("rst_err_early", 32'(err_early), 32'h0);
        chk("rst_err_late", 32'(err_late), 32'h0);
        rst_n = 1'b1;
        step();

        // Frame 1: fill, a stalled offer, run to the last beat.
        beats(8);
        chk("f1_fill_8", 32'(state), 32'h1);
        in_valid = 1'b1; in_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("f1_stall", 32'(state), 32'h1);
        beat(1'b0);
        chk("f1_run_9", 32'(state), 32'h2);
        beats(14);
        chk("f1_run_23", 32'(state), 32'h2);
        beat(1'b1);
        chk("f1_flush_24", 32'(state), 32'h4);
        chk("f1_err_early", 32'(err_early), 32'h0);
        chk("f1_err_late", 32'(err_late), 32'h0);

        // Beats offered during FLUSH are ignored, including their TLAST.
        in_valid = 1'b1; in_ready = 1'b1; in_last = 1'b1;
        step();
        step();
        in_valid = 1'b0; in_ready = 1'b0; in_last = 1'b0;
        chk("f1_flush_ign_state", 32'(state), 32'h4);
        chk("f1_flush_ign_err", 32'({err_early, err_late}), 32'h0);

        // Toggling flush_adv: eight advances keep FLUSH, the ninth enters DONE.
        for (int i = 0; i < 8; i++) begin
            flush_adv = 1'b1; step();
            flush_adv = 1'b0; step();
        end
        chk("f1_flush_8", 32'(state), 32'h4);
        chk("f1_flush_8_last", 32'(out_last), 32'h0);
        // A handshake on the edge entering DONE must not consume out_last.
        flush_adv = 1'b1; out_valid = 1'b1; out_ready = 1'b1;
        step();
        flush_adv = 1'b0; out_ready = 1'b0;
        chk("f1_done", 32'(state), 32'h8);
        chk("f1_out_last_rise", 32'(out_last), 32'h1);
        for (int i = 0; i < 5; i++) step();
        out_valid = 1'b0;
        chk("f1_hold_last", 32'(out_last), 32'h1);
        chk("f1_hold_state", 32'(state), 32'h8);
        handshake();
        chk("f1_rearm_last", 32'(out_last), 32'h0);
        chk("f1_rearm_state", 32'(state), 32'h1);
        chk("f1_rearm_frame", 32'(frame_cnt), 32'h1);

        // End-of-line on every fourth output handshake (out_col restarted at re-arm).
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("eol_hs%0d", k), 32'(out_eol), 32'((k % 4) == 0));
            handshake();
        end
        chk("eol_after", 32'(out_eol), 32'h0);

        // Frame 2: early TLAST on beat 10, missing TLAST on beat 24.
        beats(8);
        chk("f2_fill_8", 32'(state), 32'h1);
        beat(1'b0);
        chk("f2_run_9", 32'(state), 32'h2);
        beat(1'b1);
        chk("f2_err_early", 32'(err_early), 32'h1);
        chk("f2_err_late_pre", 32'(err_late), 32'h0);
        beats(13);
        chk("f2_err_late_23", 32'(err_late), 32'h0);
        beat(1'b0);
        chk("f2_err_late", 32'(err_late), 32'h1);
        chk("f2_flush", 32'(state), 32'h4);
        flush(8);
        chk("f2_flush_8", 32'(state), 32'h4);
        flush(1);
        chk("f2_done", 32'(out_last), 32'h1);
        handshake();
        chk("f2_frame", 32'(frame_cnt), 32'h2);
        chk("f2_sticky", 32'({err_early, err_late}), 32'h3);

        // Frame 3 back-to-back.
        beats(23);
        beat(1'b1);
        flush(9);
        chk("f3_done", 32'(state), 32'h8);
        handshake();
        chk("f3_frame", 32'(frame_cnt), 32'h3);
        chk("f3_state", 32'(state), 32'h1);

        // Frame 4: clr in RUN at cnt=15 beats an accepted beat in the same cycle.
        beats(15);
        chk("f4_run_15", 32'(state), 32'h2);
        clr = 1'b1; in_valid = 1'b1; in_ready = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
        chk("clr_state", 32'(state), 32'h1);
        chk("clr_frame", 32'(frame_cnt), 32'h0);
        chk("clr_err", 32'({err_early, err_late}), 32'h0);
        beats(8);
        chk("clr_fill_8", 32'(state), 32'h1);
        beat(1'b1);
        chk("clr_run_9", 32'(state), 32'h2);
        chk("clr_err_early", 32'(err_early), 32'h1);
        beats(14);
        beat(1'b1);
        chk("f4_flush", 32'(state), 32'h4);
        flush(4);

        // Asynchronous reset mid-FLUSH, applied between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'h1);
        chk("arst_out_last", 32'(out_last), 32'h0);
        chk("arst_eol", 32'(out_eol), 32'h0);
        chk("arst_frame", 32'(frame_cnt), 32'h0);
        chk("arst_err", 32'({err_early, err_late}), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        beats(8);
        chk("arst_fill_8", 32'(state), 32'h1);
        beat(1'b0);
        chk("arst_run_9", 32'(state), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
